// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU-wide constants and types used by the fetch stage.
//   XLEN     : architectural register / PC width
//   INSTR_W  : instruction word width
//   PC_STEP  : byte increment between sequential instruction words
//   fetch_entry_t : {pc, instr} pair carried through the prefetch buffer
//   align_pc : clears the two byte-offset bits of a fetch target
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with combinational head read. DEPTH must be a power of 2
// and at least 2. A push while full is accepted only when a pop happens in
// the same cycle. Flush empties the FIFO and discards any same-cycle push.
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   i_flush    : drop all entries
//   i_push     : write i_wdata at the tail
//   i_pop      : advance the head (ignored when empty)
//   o_rdata    : current head entry
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
//   o_count    : number of entries held
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_count = r_wptr - r_rptr;
    assign o_rdata = r_mem[r_rptr[AW-1:0]];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage is not reset; a write during flush lands beyond the reset
    // pointers and is never read.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage: issues sequential word reads to instruction memory, buffers
// returned words with their PCs in a prefetch FIFO and hands {pc, instr} to
// the core over valid/ready. A redirect flushes the buffer, retargets the
// fetch PC and marks every in-flight response as stale.
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   imem_req/addr   : read request and word-aligned byte address
//   imem_gnt        : memory accepts the request this cycle
//   imem_rvalid/rdata : in-order read response
//   redirect_valid/pc : core-requested PC change
//   out_valid/ready : handshake to the core
//   out_pc/instr    : head entry of the prefetch FIFO
// ----------------------------------------------------------------------------
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 4,
    parameter int              MAX_OUTST  = FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int SW = ((CW > OW) ? CW : OW) + 1;

    logic            r_active;
    logic [XLEN-1:0] r_fetch_pc;
    logic [OW-1:0]   r_outst;
    logic [OW-1:0]   r_drop;

    logic            w_active;
    logic [SW-1:0]   w_credit_used;
    logic            w_req;
    logic            w_issue;
    logic            w_resp;
    logic            w_resp_drop;
    logic            w_push;
    logic            w_pop;
    logic            w_flush;

    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [CW-1:0]   w_occ;

    logic [XLEN-1:0] w_tag_pc;
    logic            w_tag_full;
    logic            w_tag_empty;
    logic [OW-1:0]   w_tag_count;
    logic            w_unused;

    // Outputs stay quiet during reset and for one cycle after it.
    assign w_active = rst && r_active;

    // Every in-flight request owns a FIFO slot, so a response always fits.
    assign w_credit_used = SW'(w_occ) + SW'(r_outst);

    assign w_req   = w_active && !redirect_valid
                     && (w_credit_used < SW'(FIFO_DEPTH))
                     && (r_outst < OW'(MAX_OUTST))
                     && !w_tag_full;
    assign w_issue = w_req && imem_gnt;

    // A response with no tag outstanding (e.g. left over from before reset)
    // is ignored.
    assign w_resp      = w_active && imem_rvalid && !w_tag_empty;
    assign w_resp_drop = w_resp && (r_drop != '0);
    assign w_push      = w_resp && !w_resp_drop && !redirect_valid;
    assign w_flush     = redirect_valid;

    assign w_push_entry.pc    = w_tag_pc;
    assign w_push_entry.instr = imem_rdata;

    assign out_valid = w_active && !w_fifo_empty;
    assign w_pop     = out_valid && out_ready;
    assign out_pc    = out_valid ? w_head.pc    : '0;
    assign out_instr = out_valid ? w_head.instr : '0;

    assign imem_req  = w_req;
    assign imem_addr = w_active ? r_fetch_pc : '0;

    assign w_unused = ^{w_fifo_full, w_tag_count};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_active   <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_outst    <= '0;
            r_drop     <= '0;
        end else begin
            r_active <= 1'b1;
            r_outst  <= r_outst + OW'(w_issue) - OW'(w_resp);
            if (redirect_valid) begin
                r_fetch_pc <= align_pc(redirect_pc);
                // Nothing issues in a redirect cycle, so everything still in
                // flight after this edge belongs to the old stream.
                r_drop     <= r_outst - OW'(w_resp);
            end else begin
                if (w_issue)     r_fetch_pc <= r_fetch_pc + PC_STEP;
                if (w_resp_drop) r_drop     <= r_drop - OW'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_prefetch_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_occ)
    );

    // The tag queue is never flushed: stale responses still pop their tags,
    // which keeps tags aligned with returning data across redirects.
    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTST)
    ) u_tag_queue (
        .clk     (clk),
        .rst     (rst),
        .i_flush (1'b0),
        .i_push  (w_issue),
        .i_wdata (r_fetch_pc),
        .i_pop   (w_resp),
        .o_rdata (w_tag_pc),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty),
        .o_count (w_tag_count)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH),
        .MAX_OUTST  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mq[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];

    int n_tests = 0;
    int n_fail  = 0;
    int e_cnt   = 0;
    int last_due = 0;
    int lat_min = 1;
    int lat_max = 1;
    bit gnt_rand = 1'b0;
    bit chk_inv  = 1'b0;
    int n_issued = 0;
    int n_pops   = 0;
    int inv_viol = 0;

    function automatic logic [31:0] img(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    // Memory model and output monitor; everything sampled and driven on the
    // falling edge. e_cnt is the index of the upcoming rising edge.
    initial begin
        int d;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            e_cnt++;
            if (!rst) begin
                mq.delete();
                imem_rvalid = 1'b0;
                imem_gnt    = 1'b0;
                imem_rdata  = '0;
                last_due    = 0;
                n_issued    = 0;
                n_pops      = 0;
            end else begin
                if (chk_inv && (n_issued - n_pops > DEPTH)) inv_viol++;
                if (out_valid && out_ready) begin
                    got_pc.push_back(out_pc);
                    got_instr.push_back(out_instr);
                    n_pops++;
                end
                if (mq.size() > 0 && mq[0].due <= e_cnt) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = img(mq[0].addr);
                    void'(mq.pop_front());
                end else begin
                    imem_rvalid = 1'b0;
                    imem_rdata  = '0;
                end
                imem_gnt = gnt_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (imem_req && imem_gnt) begin
                    d = e_cnt + int'($urandom_range(lat_min, lat_max));
                    if (d <= last_due) d = last_due + 1;
                    last_due = d;
                    mq.push_back('{addr: imem_addr, due: d});
                    n_issued++;
                end
            end
        end
    end

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        redirect_valid = 1'b0;
        clk1();
        clk1();
        got_pc.delete();
        got_instr.delete();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        lat_min = 1; lat_max = 1; gnt_rand = 1'b0;
        rst = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        clk1();
        clk1();
        @(negedge clk);
        n_tests++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", imem_req); end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", out_valid); end
        n_tests++;
        if (imem_addr !== 32'h0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
            n_fail++; $display("FAIL rst_data: addr %h pc %h instr %h exp 0", imem_addr, out_pc, out_instr);
        end
        clk1();
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_rst_quiet: req %b valid %b exp 0 0", imem_req, out_valid);
        end
        clk1();
        @(negedge clk);
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL first_req: req %b addr %h exp 1 00000000", imem_req, imem_addr);
        end
        clk1();
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: valid %b exp 0", out_valid); end
        clk1();
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== img(32'h0)) begin
            n_fail++; $display("FAIL first_out: valid %b pc %h instr %h exp 1 0 %h", out_valid, out_pc, out_instr, img(32'h0));
        end
        clk1();
    endtask

    task automatic test_sequential();
        lat_min = 1; lat_max = 1; out_ready = 1'b1;
        do_reset();
        repeat (30) clk1();
        n_tests++;
        if (got_pc.size() < 8) begin n_fail++; $display("FAIL seq_count: got %0d exp >=8", got_pc.size()); end
        for (int i = 0; i < 8 && i < got_pc.size(); i++) begin
            n_tests++;
            if (got_pc[i] !== 32'(4 * i) || got_instr[i] !== img(32'(4 * i))) begin
                n_fail++; $display("FAIL seq_%0d: pc %h instr %h exp %h %h", i, got_pc[i], got_instr[i], 32'(4 * i), img(32'(4 * i)));
            end
        end
    endtask

    task automatic test_backpressure();
        int hold_bad = 0;
        lat_min = 1; lat_max = 1; out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid && out_pc !== 32'h0) hold_bad++;
            clk1();
        end
        n_tests++;
        if (n_issued !== DEPTH) begin n_fail++; $display("FAIL bp_issued: got %0d exp %0d", n_issued, DEPTH); end
        @(negedge clk);
        n_tests++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req: got %b exp 0", imem_req); end
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || hold_bad != 0) begin
            n_fail++; $display("FAIL bp_hold: valid %b pc %h unstable %0d exp 1 0 0", out_valid, out_pc, hold_bad);
        end
        clk1();
        out_ready = 1'b1;
        repeat (30) clk1();
        n_tests++;
        if (got_pc.size() < 10) begin n_fail++; $display("FAIL bp_count: got %0d exp >=10", got_pc.size()); end
        for (int i = 0; i < 10 && i < got_pc.size(); i++) begin
            n_tests++;
            if (got_pc[i] !== 32'(4 * i)) begin
                n_fail++; $display("FAIL bp_seq_%0d: pc %h exp %h", i, got_pc[i], 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect();
        lat_min = 3; lat_max = 3; out_ready = 1'b1;
        do_reset();
        clk1();
        clk1();
        clk1();
        clk1();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        @(negedge clk);
        n_tests++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req: got %b exp 0", imem_req); end
        clk1();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_fail++; $display("FAIL redir_next: valid %b req %b addr %h exp 0 1 00000100", out_valid, imem_req, imem_addr);
        end
        repeat (25) clk1();
        n_tests++;
        if (got_pc.size() < 2) begin
            n_fail++; $display("FAIL redir_count: got %0d exp >=2", got_pc.size());
        end else begin
            if (got_pc[0] !== 32'h100 || got_pc[1] !== 32'h104 || got_instr[0] !== img(32'h100)) begin
                n_fail++; $display("FAIL redir_seq: pc %h %h instr %h exp 100 104 %h", got_pc[0], got_pc[1], got_instr[0], img(32'h100));
            end
        end
        lat_min = 1; lat_max = 1;
    endtask

    task automatic test_redirect_align_b2b();
        int mark;
        lat_min = 1; lat_max = 1; out_ready = 1'b1;
        do_reset();
        clk1();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        clk1();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            n_fail++; $display("FAIL align_addr: req %b addr %h exp 1 00000200", imem_req, imem_addr);
        end
        repeat (10) clk1();
        n_tests++;
        if (got_pc.size() < 1 || got_pc[0] !== 32'h200) begin
            n_fail++; $display("FAIL align_out: count %0d first %h exp >=1 00000200", got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'h0);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        clk1();
        redirect_pc    = 32'h0000_0400;
        clk1();
        redirect_valid = 1'b0;
        mark = got_pc.size();
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h400) begin
            n_fail++; $display("FAIL b2b_next: valid %b addr %h exp 0 00000400", out_valid, imem_addr);
        end
        repeat (15) clk1();
        n_tests++;
        if (got_pc.size() < mark + 2) begin
            n_fail++; $display("FAIL b2b_count: got %0d exp >=%0d", got_pc.size(), mark + 2);
        end else if (got_pc[mark] !== 32'h400 || got_pc[mark+1] !== 32'h404) begin
            n_fail++; $display("FAIL b2b_seq: pc %h %h exp 00000400 00000404", got_pc[mark], got_pc[mark+1]);
        end
    endtask

    task automatic test_random();
        lat_min = 1; lat_max = 5; gnt_rand = 1'b1; out_ready = 1'b1;
        do_reset();
        inv_viol = 0;
        chk_inv  = 1'b1;
        repeat (2000) begin
            out_ready = ($urandom_range(0, 1) == 1);
            clk1();
        end
        out_ready = 1'b1;
        repeat (40) clk1();
        chk_inv = 1'b0;
        n_tests++;
        if (inv_viol != 0) begin n_fail++; $display("FAIL rnd_credit: violations %0d exp 0", inv_viol); end
        n_tests++;
        if (got_pc.size() < 100) begin n_fail++; $display("FAIL rnd_count: got %0d exp >=100", got_pc.size()); end
        for (int i = 0; i < got_pc.size(); i++) begin
            n_tests++;
            if (got_pc[i] !== 32'(4 * i) || got_instr[i] !== img(32'(4 * i))) begin
                n_fail++; $display("FAIL rnd_seq_%0d: pc %h instr %h exp %h %h", i, got_pc[i], got_instr[i], 32'(4 * i), img(32'(4 * i)));
                break;
            end
        end
        gnt_rand = 1'b0; lat_min = 1; lat_max = 1;
    endtask

    task automatic test_reset_mid();
        lat_min = 2; lat_max = 2; out_ready = 1'b1;
        do_reset();
        repeat (8) clk1();
        rst = 1'b0;
        clk1();
        @(negedge clk);
        n_tests++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0 || out_pc !== 32'h0 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL mid_rst_out: req %b valid %b pc %h addr %h exp all 0", imem_req, out_valid, out_pc, imem_addr);
        end
        clk1();
        rst = 1'b1;
        got_pc.delete();
        got_instr.delete();
        @(negedge clk);
        n_tests++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mid_rst_quiet: req %b exp 0", imem_req); end
        clk1();
        @(negedge clk);
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL mid_rst_restart: req %b addr %h exp 1 00000000", imem_req, imem_addr);
        end
        repeat (15) clk1();
        n_tests++;
        if (got_pc.size() < 2) begin
            n_fail++; $display("FAIL mid_rst_count: got %0d exp >=2", got_pc.size());
        end else if (got_pc[0] !== 32'h0 || got_pc[1] !== 32'h4) begin
            n_fail++; $display("FAIL mid_rst_seq: pc %h %h exp 00000000 00000004", got_pc[0], got_pc[1]);
        end
    endtask

    initial begin
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_redirect_align_b2b();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
